// File: rtl/keystream_xor_cipher.sv
// Keystream XOR cipher.
// Chaotic key samples are queued in a small FIFO, assembled into OUT_WIDTH-bit
// keystream words, and XORed with plaintext words to produce ciphertext.
// Direct mode uses the low bits of a single sample as the keystream word.
// Threshold mode builds the word one bit per sample, LSB first, where each bit
// is (sample > THRESHOLD).
//
// Assembler states:
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_COLLECT | popping key samples to build the next keystream word
//   S_HOLD    | keystream word complete, waiting for a plaintext word
module keystream_xor_cipher #(
    parameter int                    DATA_WIDTH = 12,
    parameter int                    OUT_WIDTH  = 8,
    parameter int                    KEY_DEPTH  = 16,
    parameter logic [DATA_WIDTH-1:0] THRESHOLD  = 12'h080
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH-1:0]            key_in,
    input  logic                             key_valid,
    output logic                             key_ready,
    input  logic [OUT_WIDTH-1:0]             pt_data,
    input  logic                             pt_valid,
    output logic                             pt_ready,
    output logic [OUT_WIDTH-1:0]             ct_data,
    output logic                             ct_valid,
    input  logic                             ct_ready,
    input  logic                             mode,
    input  logic                             clear,
    output logic [$clog2(KEY_DEPTH+1)-1:0]   key_count,
    output logic [15:0]                      byte_count
);

    localparam int CW = $clog2(KEY_DEPTH + 1);
    localparam int PW = $clog2(KEY_DEPTH);
    localparam int BW = $clog2(OUT_WIDTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(KEY_DEPTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(OUT_WIDTH - 1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    // Key FIFO storage and pointers
    logic [DATA_WIDTH-1:0] r_mem [KEY_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    // Assembler state
    state_t                r_state;
    state_t                w_state_nxt;
    logic [BW-1:0]         r_bit_cnt;
    logic [BW-1:0]         w_bit_cnt_nxt;
    logic [OUT_WIDTH-1:0]  r_ks;
    logic [OUT_WIDTH-1:0]  w_ks_nxt;
    logic                  r_active_mode;
    logic                  w_active_mode_nxt;

    // Ciphertext output stage
    logic [OUT_WIDTH-1:0]  r_ct_data;
    logic                  r_ct_valid;
    logic [15:0]           r_byte_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_pt_fire;
    logic                  w_ct_fire;
    logic                  w_eff_mode;
    logic [DATA_WIDTH-1:0] w_sample;

    assign key_ready  = (r_count < DEPTH_C);
    assign pt_ready   = (r_state == S_HOLD) && (!r_ct_valid || ct_ready) && !clear;
    assign ct_data    = r_ct_data;
    assign ct_valid   = r_ct_valid;
    assign key_count  = r_count;
    assign byte_count = r_byte_count;

    assign w_push    = key_valid && key_ready && !clear;
    assign w_pt_fire = pt_valid && pt_ready;
    assign w_ct_fire = r_ct_valid && ct_ready;
    assign w_sample  = r_mem[r_rd_ptr];
    // A word that is just starting uses the live mode input; mid-word uses the latched one.
    assign w_eff_mode = (r_bit_cnt == '0) ? mode : r_active_mode;

    // FIFO storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= key_in;
        end
    end

    // FIFO pointers and occupancy, with simultaneous push/pop leaving the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Assembler state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_COLLECT;
            r_bit_cnt     <= '0;
            r_ks          <= '0;
            r_active_mode <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_ks          <= w_ks_nxt;
            r_active_mode <= w_active_mode_nxt;
        end
    end

    // Assembler next-state: pop and fold samples into the keystream, hand off on plaintext
    always_comb begin
        w_state_nxt       = r_state;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_ks_nxt          = r_ks;
        w_active_mode_nxt = r_active_mode;
        w_pop             = 1'b0;
        if (clear) begin
            w_state_nxt   = S_COLLECT;
            w_bit_cnt_nxt = '0;
            w_ks_nxt      = '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (r_bit_cnt == '0) begin
                        w_active_mode_nxt = mode;
                    end
                    if (r_count != '0) begin
                        w_pop = 1'b1;
                        if (!w_eff_mode) begin
                            w_ks_nxt    = w_sample[OUT_WIDTH-1:0];
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_ks_nxt[r_bit_cnt] = (w_sample > THRESHOLD);
                            if (r_bit_cnt == BIT_LAST) begin
                                w_bit_cnt_nxt = '0;
                                w_state_nxt   = S_HOLD;
                            end else begin
                                w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (w_pt_fire) begin
                        w_state_nxt = S_COLLECT;
                    end
                end
                default: begin
                    w_state_nxt = S_COLLECT;
                end
            endcase
        end
    end

    // Ciphertext register: load on plaintext handshake, hold under backpressure, zero when drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ct_data  <= '0;
            r_ct_valid <= 1'b0;
        end else if (clear) begin
            r_ct_data  <= '0;
            r_ct_valid <= 1'b0;
        end else if (w_pt_fire) begin
            r_ct_data  <= pt_data ^ r_ks;
            r_ct_valid <= 1'b1;
        end else if (w_ct_fire) begin
            r_ct_data  <= '0;
            r_ct_valid <= 1'b0;
        end
    end

    // Downstream accepted-word counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_count <= '0;
        end else if (clear) begin
            r_byte_count <= '0;
        end else if (w_ct_fire) begin
            r_byte_count <= r_byte_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_keystream_xor_cipher.sv
// Directed bench for keystream_xor_cipher: direct and threshold modes,
// backpressure, FIFO full, clear with mid-word mode change, async reset.
module tb_keystream_xor_cipher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] key_in;
    logic        key_valid;
    logic        key_ready;
    logic [7:0]  pt_data;
    logic        pt_valid;
    logic        pt_ready;
    logic [7:0]  ct_data;
    logic        ct_valid;
    logic        ct_ready;
    logic        mode;
    logic        clear;
    logic [4:0]  key_count;
    logic [15:0] byte_count;

    int n_checks = 0;
    int n_errors = 0;

    keystream_xor_cipher #(
        .DATA_WIDTH (12),
        .OUT_WIDTH  (8),
        .KEY_DEPTH  (16),
        .THRESHOLD  (12'h080)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .pt_data    (pt_data),
        .pt_valid   (pt_valid),
        .pt_ready   (pt_ready),
        .ct_data    (ct_data),
        .ct_valid   (ct_valid),
        .ct_ready   (ct_ready),
        .mode       (mode),
        .clear      (clear),
        .key_count  (key_count),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [11:0] thr_keys [8];
    logic [11:0] mix_keys [8];
    int          accepted;

    initial begin
        thr_keys = '{12'h081, 12'h000, 12'h080, 12'hFFF, 12'h100, 12'h07F, 12'h200, 12'h001};
        mix_keys = '{12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF};

        rst_n = 1'b0; key_in = '0; key_valid = 0; pt_data = '0; pt_valid = 0;
        ct_ready = 1'b1; mode = 1'b0; clear = 1'b0;
        tick(); tick();
        check("rst_ct_valid", 32'(ct_valid), 32'd0);
        check("rst_ct_data", 32'(ct_data), 32'd0);
        check("rst_key_count", 32'(key_count), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        check("rst_key_ready", 32'(key_ready), 32'd1);
        check("rst_pt_ready", 32'(pt_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // Direct mode: A5C -> ks 5C, 3C ^ 5C = 60
        key_in = 12'hA5C; key_valid = 1; tick();
        check("dir_count_after_push", 32'(key_count), 32'd1);
        key_valid = 0; tick();
        check("dir_count_after_pop", 32'(key_count), 32'd0);
        check("dir_pt_ready", 32'(pt_ready), 32'd1);
        pt_data = 8'h3C; pt_valid = 1; tick();
        pt_valid = 0;
        check("dir_ct_valid", 32'(ct_valid), 32'd1);
        check("dir_ct_data", 32'(ct_data), 32'h60);
        tick();
        check("dir_ct_valid_drop", 32'(ct_valid), 32'd0);
        check("dir_ct_data_zero", 32'(ct_data), 32'd0);
        check("dir_byte_count", 32'(byte_count), 32'd1);

        // Threshold mode: ks 59, FF ^ 59 = A6
        mode = 1;
        for (int i = 0; i < 8; i++) begin
            key_in = thr_keys[i]; key_valid = 1; tick();
            if (i == 6) check("thr_not_ready_midword", 32'(pt_ready), 32'd0);
        end
        key_valid = 0;
        check("thr_pt_ready_before_last", 32'(pt_ready), 32'd0);
        tick();
        check("thr_pt_ready", 32'(pt_ready), 32'd1);
        pt_data = 8'hFF; pt_valid = 1; tick();
        pt_valid = 0;
        check("thr_ct_data", 32'(ct_data), 32'hA6);
        check("thr_ct_valid", 32'(ct_valid), 32'd1);
        tick();
        check("thr_byte_count", 32'(byte_count), 32'd2);

        // Backpressure: first ct E2 held, second 0F ^ 34 = 3B after handshake
        mode = 0; ct_ready = 0;
        key_in = 12'h012; key_valid = 1; tick();
        key_in = 12'h034; tick();
        key_valid = 0;
        pt_data = 8'hF0; pt_valid = 1; #1;
        check("bp_pt_ready_first", 32'(pt_ready), 32'd1);
        tick();
        pt_data = 8'h0F;
        check("bp_first_ct", 32'(ct_data), 32'hE2);
        tick();
        check("bp_pt_ready_blocked", 32'(pt_ready), 32'd0);
        tick();
        check("bp_hold_data", 32'(ct_data), 32'hE2);
        check("bp_hold_valid", 32'(ct_valid), 32'd1);
        check("bp_hold_pt_ready", 32'(pt_ready), 32'd0);
        ct_ready = 1; #1;
        check("bp_pt_ready_release", 32'(pt_ready), 32'd1);
        tick();
        pt_valid = 0;
        check("bp_second_ct", 32'(ct_data), 32'h3B);
        check("bp_second_valid", 32'(ct_valid), 32'd1);
        check("bp_byte_count_1", 32'(byte_count), 32'd3);
        tick();
        check("bp_drained", 32'(ct_valid), 32'd0);
        check("bp_byte_count_2", 32'(byte_count), 32'd4);

        // Full: 20 offered, 17 accepted (one in HOLD, 16 queued)
        accepted = 0;
        key_valid = 1;
        for (int i = 0; i < 20; i++) begin
            key_in = 12'(i);
            if (key_ready) accepted++;
            tick();
        end
        key_valid = 0;
        check("full_accepted", 32'(accepted), 32'd17);
        check("full_key_count", 32'(key_count), 32'd16);
        check("full_key_ready", 32'(key_ready), 32'd0);
        clear = 1; tick(); clear = 0;
        check("full_clear_count", 32'(key_count), 32'd0);
        check("full_clear_bytes", 32'(byte_count), 32'd0);
        check("full_clear_pt_ready", 32'(pt_ready), 32'd0);

        // Clear mid-word in threshold mode, then 8 fresh keys with mode toggled mid-word
        mode = 1;
        for (int i = 0; i < 3; i++) begin
            key_in = 12'hFFF; key_valid = 1; tick();
        end
        key_valid = 0; clear = 1; tick(); clear = 0;
        check("clr_key_count", 32'(key_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            key_in = mix_keys[i]; key_valid = 1; tick();
            if (i == 1) mode = 0;
        end
        key_valid = 0;
        check("clr_not_ready_7bits", 32'(pt_ready), 32'd0);
        tick();
        check("clr_ready_8bits", 32'(pt_ready), 32'd1);
        pt_data = 8'h00; pt_valid = 1; tick(); pt_valid = 0;
        check("clr_ks_threshold", 32'(ct_data), 32'h86);
        key_in = 12'h0AB; key_valid = 1; tick(); key_valid = 0; tick();
        check("mode_direct_ready", 32'(pt_ready), 32'd1);
        pt_data = 8'h00; pt_valid = 1; tick(); pt_valid = 0;
        check("mode_direct_ks", 32'(ct_data), 32'hAB);
        tick();

        // Async reset with ct_valid = 1 and 5 keys queued
        ct_ready = 0; mode = 0;
        key_in = 12'h055; key_valid = 1; tick();
        key_in = 12'h056; tick();
        key_in = 12'h057; pt_data = 8'h11; pt_valid = 1; tick();
        pt_valid = 0;
        key_in = 12'h058; tick();
        key_in = 12'h059; tick();
        key_in = 12'h05A; tick();
        key_in = 12'h05B; tick();
        key_valid = 0;
        check("rm_pre_ct_valid", 32'(ct_valid), 32'd1);
        check("rm_pre_key_count", 32'(key_count), 32'd5);
        #2;
        rst_n = 0;
        #1;
        check("rm_ct_valid", 32'(ct_valid), 32'd0);
        check("rm_ct_data", 32'(ct_data), 32'd0);
        check("rm_key_count", 32'(key_count), 32'd0);
        check("rm_byte_count", 32'(byte_count), 32'd0);
        check("rm_key_ready", 32'(key_ready), 32'd1);
        check("rm_pt_ready", 32'(pt_ready), 32'd0);
        tick();
        rst_n = 1; ct_ready = 1;
        tick(); tick();
        check("rm_post_pt_ready", 32'(pt_ready), 32'd0);
        check("rm_post_ct_valid", 32'(ct_valid), 32'd0);
        check("rm_post_key_count", 32'(key_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keystream_xor_cipher.md
KEYSTREAM_XOR_CIPHER -- requirements
Module: keystream_xor_cipher

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, width of each chaotic key sample.
REQ-002 SHALL have parameter OUT_WIDTH, default 8, width of plaintext/ciphertext words (2..DATA_WIDTH).
REQ-003 SHALL have parameter KEY_DEPTH, default 16, key FIFO depth (power of two, at least 2).
REQ-004 SHALL have parameter THRESHOLD, default 12'h080, threshold-mode comparison level (unsigned).
REQ-005 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports key_in (input, DATA_WIDTH), key_valid (input, 1) and key_ready (output, 1): the key sample stream.
REQ-008 SHALL have ports pt_data (input, OUT_WIDTH), pt_valid (input, 1) and pt_ready (output, 1): the plaintext stream.
REQ-009 SHALL have ports ct_data (output, OUT_WIDTH), ct_valid (output, 1) and ct_ready (input, 1): the ciphertext stream.
REQ-010 SHALL have port mode, input, 1: 0 = direct mode, 1 = threshold mode.
REQ-011 SHALL have port clear, input, 1, synchronous flush.
REQ-012 SHALL have port key_count, output, clog2(KEY_DEPTH+1), FIFO occupancy.
REQ-013 SHALL have port byte_count, output, 16, count of ciphertext words accepted downstream.

Function
REQ-014 SHALL accept a key sample into the FIFO on any edge where key_valid && key_ready; key_ready = (key_count < KEY_DEPTH), with no same-cycle pass-through when full.
REQ-015 SHALL support a simultaneous push and pop in one cycle, leaving key_count unchanged.
REQ-016 SHALL implement a keystream assembler FSM with states COLLECT and HOLD, and a bit counter bit_cnt.
REQ-017 SHALL latch mode into an active-mode register only in COLLECT with bit_cnt == 0; mode changes mid-word take effect at the next keystream word.
REQ-018 In COLLECT with a non-empty FIFO, the assembler SHALL pop one sample per cycle.
REQ-019 In direct mode, SHALL set ks = sample[OUT_WIDTH-1:0] and go to HOLD on that pop.
REQ-020 In threshold mode, SHALL set ks[bit_cnt] = (sample > THRESHOLD) and increment bit_cnt, filling LSB first; the pop at bit_cnt == OUT_WIDTH-1 SHALL reset bit_cnt to 0 and go to HOLD.
REQ-021 pt_ready SHALL equal (state == HOLD) && (!ct_valid || ct_ready) && !clear.
REQ-022 On pt_valid && pt_ready, SHALL register ct_data = pt_data ^ ks, set ct_valid = 1 the next cycle (1-cycle latency), and return the FSM to COLLECT with no pop that cycle.
REQ-023 While ct_valid && !ct_ready, ct_data and ct_valid SHALL hold stable.
REQ-024 On ct_valid && ct_ready with no new word loaded, SHALL clear ct_valid and ct_data to 0 the next cycle.
REQ-025 SHALL increment byte_count by 1 on each ct_valid && ct_ready, wrapping 16'hFFFF -> 0.
REQ-026 clear SHALL take priority over all other activity and, on the next edge:
- empty the FIFO (key_count = 0)
- discard any partial or held keystream (state COLLECT, bit_cnt 0)
- set ct_valid = 0 and ct_data = 0
- set byte_count = 0
- ignore any push or plaintext presented that cycle.

Reset
REQ-027 While rst_n is low, SHALL force ct_data = 0, ct_valid = 0, key_count = 0, byte_count = 0, state COLLECT, bit_cnt = 0, ks = 0 and active mode = 0, regardless of clk.
REQ-028 After reset, key_ready SHALL be 1 and pt_ready SHALL be 0.
REQ-029 Reset asserted mid-word SHALL discard all FIFO contents and any partial keystream, with no ciphertext emitted.

Verification
REQ-030 Direct mode: push key 12'hA5C, then pt 8'h3C with ct_ready = 1 -> ct_data = 8'h60, ct_valid for 1 cycle, byte_count = 1.
REQ-031 Threshold mode: push keys 081, 000, 080, FFF, 100, 07F, 200, 001, then pt 8'hFF -> ks = 8'h59, ct_data = 8'hA6.
REQ-032 Backpressure: ct_ready = 0 with two plaintexts and ample keys -> first ct holds stable, pt_ready = 0 until ct_ready rises, and the second ct follows 1 cycle after the handshake.
REQ-033 Full: direct mode, pt_valid = 0, push 20 keys -> 17 accepted (1 in HOLD, 16 queued), key_ready = 0, key_count = 16.
REQ-034 Clear and mode: in threshold mode, clear pulsed after 3 keys -> key_count = 0, the next ks needs 8 fresh keys; toggling mode mid-word changes nothing until that word completes.
REQ-035 Reset mid-operation: rst_n low for 1 cycle with ct_valid = 1 and FIFO holding 5 keys -> all outputs return to their reset values immediately.
